// File: rtl/idct_pkg.sv
// Shared constants and types for the IDCT pixel output stage.
// Optional feature macro used by the top: IDCT_SCALER_SAT_STATS_EN.
package idct_pkg;

  localparam int unsigned IDCT_OUT_W       = 32;
  localparam int unsigned IDCT_FRAC_BITS   = 8;
  localparam int unsigned IDCT_PIX_W       = 8;
  localparam int unsigned IDCT_BLK_DIM     = 8;
  localparam int unsigned JPEG_LEVEL_SHIFT = 128;

  // Packs as {high, low}, matching the out_sat port layout.
  typedef struct packed {
    logic high;
    logic low;
  } sat_t;

endpackage

// File: rtl/idct_round_clamp.sv
// Combinational round / level-shift / clamp for one IDCT sample.
// Rounding feeds the S1 register; clamping consumes the registered rounded value.
module idct_round_clamp
  import idct_pkg::*;
#(
  parameter int unsigned IN_W        = IDCT_OUT_W,
  parameter int unsigned FRAC_BITS   = IDCT_FRAC_BITS,
  parameter int unsigned PIX_W       = IDCT_PIX_W,
  parameter int unsigned LEVEL_SHIFT = JPEG_LEVEL_SHIFT
) (
  input  logic [IN_W-1:0]        in_data,
  output logic signed [IN_W+1:0] rounded,
  input  logic signed [IN_W+1:0] rounded_in,
  output logic [PIX_W-1:0]       pixel,
  output sat_t                   sat
);

  localparam int unsigned IW = IN_W + 2;
  localparam logic signed [IW-1:0] HALF    = IW'(1) <<< (FRAC_BITS - 1);
  localparam logic signed [IW-1:0] SHIFT   = IW'(LEVEL_SHIFT);
  localparam logic signed [IW-1:0] PIX_MAX = IW'((64'd1 << PIX_W) - 64'd1);

  logic signed [IW-1:0] in_ext;
  logic signed [IW-1:0] shifted;

  // Two guard bits keep the +HALF add from wrapping at the input extremes.
  assign in_ext  = {{2{in_data[IN_W-1]}}, in_data};
  assign rounded = (in_ext + HALF) >>> FRAC_BITS;
  assign shifted = rounded_in + SHIFT;

  always_comb begin
    pixel    = shifted[PIX_W-1:0];
    sat.high = 1'b0;
    sat.low  = 1'b0;
    if (shifted < 0) begin
      pixel   = '0;
      sat.low = 1'b1;
    end else if (shifted > PIX_MAX) begin
      pixel    = '1;
      sat.high = 1'b1;
    end
  end

endmodule

// File: rtl/idct_pixel_stream_scaler.sv
// Two-stage valid/ready pipeline turning IDCT results into clamped, position-tagged pixels.
// Define IDCT_SCALER_SAT_STATS_EN to add per-block saturation counters.
module idct_pixel_stream_scaler
  import idct_pkg::*;
#(
  parameter int unsigned IN_W        = IDCT_OUT_W,
  parameter int unsigned FRAC_BITS   = IDCT_FRAC_BITS,
  parameter int unsigned PIX_W       = IDCT_PIX_W,
  parameter int unsigned LEVEL_SHIFT = JPEG_LEVEL_SHIFT,
  parameter int unsigned BLK_DIM     = IDCT_BLK_DIM
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PIX_W-1:0]           out_pixel,
  output logic [$clog2(BLK_DIM)-1:0] out_row,
  output logic [$clog2(BLK_DIM)-1:0] out_col,
  output logic                       out_last,
  output logic [1:0]                 out_sat
`ifdef IDCT_SCALER_SAT_STATS_EN
  ,
  output logic [15:0]                sat_count,
  output logic [15:0]                blk_sat_count
`endif
);

  localparam int unsigned PW = $clog2(BLK_DIM);
  localparam logic [PW-1:0] POS_MAX = PW'(BLK_DIM - 1);

  logic                   s1_valid_q, s2_valid_q;
  logic signed [IN_W+1:0] s1_data_q;
  logic [PIX_W-1:0]       s2_pixel_q;
  sat_t                   s2_sat_q;
  logic [PW-1:0]          row_q, col_q;

  logic signed [IN_W+1:0] rounded;
  logic [PIX_W-1:0]       pixel;
  sat_t                   sat;
  logic                   s1_adv, s2_adv, out_fire;

  idct_round_clamp #(
    .IN_W        (IN_W),
    .FRAC_BITS   (FRAC_BITS),
    .PIX_W       (PIX_W),
    .LEVEL_SHIFT (LEVEL_SHIFT)
  ) u_round_clamp (
    .in_data    (in_data),
    .rounded    (rounded),
    .rounded_in (s1_data_q),
    .pixel      (pixel),
    .sat        (sat)
  );

  // A stage may load when it is empty or its content moves on this edge.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign out_fire = s2_valid_q && out_ready;

  assign out_valid = s2_valid_q;
  assign out_pixel = s2_pixel_q;
  assign out_sat   = s2_sat_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_last  = (row_q == POS_MAX) && (col_q == POS_MAX) && s2_valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_pixel_q <= '0;
      s2_sat_q   <= '0;
      row_q      <= '0;
      col_q      <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) s1_data_q <= rounded;
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_pixel_q <= pixel;
          s2_sat_q   <= sat;
        end
      end
      // Position tracks delivered pixels, so stalls never move it.
      if (out_fire) begin
        if (col_q == POS_MAX) begin
          col_q <= '0;
          row_q <= (row_q == POS_MAX) ? '0 : row_q + PW'(1);
        end else begin
          col_q <= col_q + PW'(1);
        end
      end
    end
  end

`ifdef IDCT_SCALER_SAT_STATS_EN
  logic [15:0] cnt_q, blk_q, cnt_base, cnt_next;
  logic        clr_q;

  // The running count restarts on the first transfer following a block's last pixel.
  always_comb begin
    cnt_base = clr_q ? 16'd0 : cnt_q;
    cnt_next = cnt_base;
    if ((out_sat != 2'b00) && (cnt_base != 16'hFFFF)) cnt_next = cnt_base + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      blk_q <= '0;
      clr_q <= 1'b0;
    end else if (out_fire) begin
      cnt_q <= cnt_next;
      clr_q <= out_last;
      if (out_last) blk_q <= cnt_next;
    end
  end

  assign sat_count     = cnt_q;
  assign blk_sat_count = blk_q;
`endif

endmodule
